// File: rtl/thee_pg_amp_ramp.sv
// Multi-channel programmable-gain amplifier model with clipped, registered outputs.
// Gain changes walk one code at a time, dwelling RAMP_CYCLES clocks per code.
module thee_pg_amp_ramp #(
    parameter int  NUM_CH      = 4,
    parameter int  GAIN_BITS   = 3,
    parameter real GAIN_STEP   = 1.0,
    parameter int  RAMP_CYCLES = 4,
    parameter real CLIP_LEVEL  = 10.0,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  real                  sig_in [NUM_CH],
    input  logic                 gain_wr,
    input  logic [CH_W-1:0]      gain_ch,
    input  logic [GAIN_BITS-1:0] gain_code,
    output real                  sig_out [NUM_CH],
    output logic [NUM_CH-1:0]    busy,
    output logic [NUM_CH-1:0]    clip,
    output logic                 wr_err
);

    localparam int TMR_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RAMP_CYCLES - 1);
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    logic wr_err_reg;

    // gain_ch is one bit wider here so a power-of-two NUM_CH still compares cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_reg <= 1'b0;
        end else begin
            wr_err_reg <= gain_wr && ({1'b0, gain_ch} >= NUM_CH_L);
        end
    end

    assign wr_err = wr_err_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t               state_reg, state_next;
            logic [GAIN_BITS-1:0] cur_reg, cur_next;
            logic [GAIN_BITS-1:0] tgt_reg, tgt_next;
            logic [TMR_W-1:0]     timer_reg, timer_next;
            logic                 wr_hit;
            real                  raw;
            real                  sig_out_reg;
            logic                 clip_reg;

            assign wr_hit = gain_wr && (gain_ch == CH_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= IDLE;
                    cur_reg   <= '0;
                    tgt_reg   <= '0;
                    timer_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    cur_reg   <= cur_next;
                    tgt_reg   <= tgt_next;
                    timer_reg <= timer_next;
                end
            end

            // Step with the old target first; a same-edge write is then judged
            // against the post-step code.
            always_comb begin
                state_next = state_reg;
                cur_next   = cur_reg;
                tgt_next   = tgt_reg;
                timer_next = timer_reg;

                if (state_reg == RAMP) begin
                    if (timer_reg == TMR_LAST) begin
                        timer_next = '0;
                        if (tgt_reg > cur_reg) begin
                            cur_next = cur_reg + GAIN_BITS'(1);
                        end else begin
                            cur_next = cur_reg - GAIN_BITS'(1);
                        end
                        if (cur_next == tgt_reg) begin
                            state_next = IDLE;
                        end
                    end else begin
                        timer_next = timer_reg + TMR_W'(1);
                    end
                end

                if (wr_hit) begin
                    tgt_next = gain_code;
                    if (gain_code == cur_next) begin
                        state_next = IDLE;
                        timer_next = '0;
                    end else if (state_reg == IDLE) begin
                        state_next = RAMP;
                        timer_next = '0;
                    end else begin
                        state_next = RAMP;
                    end
                end
            end

            always_comb begin
                raw = sig_in[gi] * real'(int'(cur_reg) + 1) * GAIN_STEP;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sig_out_reg <= 0.0;
                    clip_reg    <= 1'b0;
                end else if (raw > CLIP_LEVEL) begin
                    sig_out_reg <= CLIP_LEVEL;
                    clip_reg    <= 1'b1;
                end else if (raw < -CLIP_LEVEL) begin
                    sig_out_reg <= -CLIP_LEVEL;
                    clip_reg    <= 1'b1;
                end else begin
                    sig_out_reg <= raw;
                    clip_reg    <= 1'b0;
                end
            end

            assign sig_out[gi] = sig_out_reg;
            assign clip[gi]    = clip_reg;
            assign busy[gi]    = (state_reg == RAMP);
        end
    endgenerate

endmodule

// File: tb/tb_thee_pg_amp_ramp.sv
// Randomized bench for thee_pg_amp_ramp against a schedule-based reference model.
// Ramps are modelled as absolute edge numbers at which the next code step lands.
module tb_thee_pg_amp_ramp;

    localparam int  NUM_CH      = 3;
    localparam int  GAIN_BITS   = 3;
    localparam real GAIN_STEP   = 1.0;
    localparam int  RAMP_CYCLES = 4;
    localparam real CLIP_LEVEL  = 10.0;
    localparam int  CH_W        = 2;
    localparam int  NUM_GAINS   = 1 << GAIN_BITS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    real                  sig_in [NUM_CH];
    logic                 gain_wr = 1'b0;
    logic [CH_W-1:0]      gain_ch = '0;
    logic [GAIN_BITS-1:0] gain_code = '0;
    real                  sig_out [NUM_CH];
    logic [NUM_CH-1:0]    busy;
    logic [NUM_CH-1:0]    clip;
    logic                 wr_err;

    thee_pg_amp_ramp #(
        .NUM_CH     (NUM_CH),
        .GAIN_BITS  (GAIN_BITS),
        .GAIN_STEP  (GAIN_STEP),
        .RAMP_CYCLES(RAMP_CYCLES),
        .CLIP_LEVEL (CLIP_LEVEL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .gain_wr  (gain_wr),
        .gain_ch  (gain_ch),
        .gain_code(gain_code),
        .sig_out  (sig_out),
        .busy     (busy),
        .clip     (clip),
        .wr_err   (wr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: codes plus the absolute edge of the next pending step
    int  edge_num = 0;
    int  m_cur [NUM_CH];
    int  m_tgt [NUM_CH];
    int  m_next_step [NUM_CH];
    bit  m_ramp [NUM_CH];
    real e_out [NUM_CH];
    bit  e_clip [NUM_CH];
    bit  e_err;

    task automatic check_val(input string tag, input real obs, input real exp_v);
        real d;
        checks++;
        d = obs - exp_v;
        if (d < 0.0) d = -d;
        if (d > 1.0e-6) begin
            failures++;
            $display("FAIL %s: got %f expected %f at t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cur[c] = 0;
            m_tgt[c] = 0;
            m_next_step[c] = 0;
            m_ramp[c] = 1'b0;
            e_out[c] = 0.0;
            e_clip[c] = 1'b0;
        end
        e_err = 1'b0;
    endtask

    task automatic model_edge();
        bit  was_ramp;
        real raw;
        int  ch;
        edge_num++;
        ch = int'(gain_ch);
        e_err = gain_wr && (ch >= NUM_CH);
        for (int c = 0; c < NUM_CH; c++) begin
            raw = sig_in[c] * (m_cur[c] + 1) * GAIN_STEP;
            if (raw > CLIP_LEVEL) begin
                e_out[c] = CLIP_LEVEL; e_clip[c] = 1'b1;
            end else if (raw < -CLIP_LEVEL) begin
                e_out[c] = -CLIP_LEVEL; e_clip[c] = 1'b1;
            end else begin
                e_out[c] = raw; e_clip[c] = 1'b0;
            end
            was_ramp = m_ramp[c];
            if (m_ramp[c] && edge_num == m_next_step[c]) begin
                m_cur[c] += (m_tgt[c] > m_cur[c]) ? 1 : -1;
                m_next_step[c] = edge_num + RAMP_CYCLES;
                if (m_cur[c] == m_tgt[c]) m_ramp[c] = 1'b0;
            end
            if (gain_wr && ch == c) begin
                m_tgt[c] = int'(gain_code);
                if (m_tgt[c] == m_cur[c]) begin
                    m_ramp[c] = 1'b0;
                end else if (!was_ramp) begin
                    m_ramp[c] = 1'b1;
                    m_next_step[c] = edge_num + RAMP_CYCLES;
                end else begin
                    m_ramp[c] = 1'b1;
                end
            end
            if (m_cur[c] < 0 || m_cur[c] >= NUM_GAINS) m_cur[c] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < NUM_CH; c++) begin
            check_val($sformatf("sig_out%0d", c), sig_out[c], e_out[c]);
            check_val($sformatf("busy%0d", c), real'(busy[c]), real'(m_ramp[c]));
            check_val($sformatf("clip%0d", c), real'(clip[c]), real'(e_clip[c]));
        end
        check_val("wr_err", real'(wr_err), real'(e_err));
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_write(input int ch, input int code);
        gain_wr = 1'b1;
        gain_ch = CH_W'(ch);
        gain_code = GAIN_BITS'(code);
        $display("write ch=%0d code=%0d edge=%0d", ch, code, edge_num + 1);
        step_cycle();
        gain_wr = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int v;
        for (int c = 0; c < NUM_CH; c++) sig_in[c] = 0.0;
        model_reset();
        #1;
        check_outputs();
        sig_in[0] = 2.0;
        #11 rst_n = 1'b1;

        // plain unity gain after reset
        step_cycle();
        check_val("first_out0", sig_out[0], 2.0);

        // ch0 ramp 0 -> 3
        sig_in[0] = 1.0;
        do_write(0, 3);
        check_val("ramp_busy0", real'(busy[0]), 1.0);
        run(13);
        check_val("ramp_end_out0", sig_out[0], 4.0);
        check_val("ramp_end_busy0", real'(busy[0]), 0.0);

        // ch1 reversal mid-ramp
        sig_in[1] = 1.0;
        do_write(1, 7);
        run(4);
        do_write(1, 0);
        run(2);
        check_val("rev_busy1_mid", real'(busy[1]), 1.0);
        step_cycle();
        check_val("rev_busy1_done", real'(busy[1]), 0.0);
        step_cycle();
        check_val("rev_out1", sig_out[1], 1.0);

        // ch2 clipping at gain 4
        sig_in[2] = 1.0;
        do_write(2, 3);
        run(13);
        sig_in[2] = 3.0;
        step_cycle();
        check_val("clip_pos", sig_out[2], 10.0);
        sig_in[2] = -3.0;
        step_cycle();
        check_val("clip_neg", sig_out[2], -10.0);
        sig_in[2] = 2.0;
        step_cycle();
        check_val("noclip", sig_out[2], 8.0);
        sig_in[2] = 2.5;
        step_cycle();
        check_val("edge_level_clip", real'(clip[2]), 0.0);

        // invalid channel, then same-code write
        do_write(3, 5);
        check_val("wr_err_pulse", real'(wr_err), 1.0);
        step_cycle();
        check_val("wr_err_clear", real'(wr_err), 0.0);
        do_write(2, 3);
        check_val("same_code_busy", real'(busy[2]), 0.0);

        // async reset mid-ramp, then ramp again from zero
        do_write(0, 6);
        run(5);
        async_reset();
        check_val("rst_out0", sig_out[0], 0.0);
        do_write(0, 1);
        run(RAMP_CYCLES + 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                v = int'($urandom_range(0, 2000));
                sig_in[c] = real'(v - 1000) / 100.0;
            end
            if ($urandom_range(0, 99) == 0) async_reset();
            if ($urandom_range(0, 2) == 0) do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, NUM_GAINS - 1)));
            else step_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
